fifo_burst_reader: RTL and testbench
====================================

# fifo_burst_reader

Read-side controller for the `sync_fifo` family (FWFT mode). Drains the FIFO in fixed-length bursts and presents them on a registered valid/ready stream with a `m_last` marker. It waits until `fifo_rd_data_count` shows a full burst, or until a programmable idle timeout expires with a partial burst pending. It sits between a `sync_fifo` read port and a downstream burst consumer such as a DMA or packetiser.

## Interface
- `DATA_WIDTH`, 16: width of FIFO output word and stream data.
- `FIFO_DEPTH`, 16: read depth of the attached FIFO; sets count width `$clog2(FIFO_DEPTH)+1`.
- `BURST_LEN`, 8: words per full burst; legal range 1..FIFO_DEPTH.
- `TIMEOUT`, 64: idle cycles before a partial burst is flushed; 0 disables partial flush.
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `fifo_valid`  in  1  FWFT head word valid.
- `fifo_dout`  in  DATA_WIDTH  FWFT head word.
- `fifo_rd_data_count`  in  $clog2(FIFO_DEPTH)+1  words stored in FIFO.
- `fifo_rd_en`  out  1  pop head word; combinational.
- `m_valid`  out  1  stream word valid; registered.
- `m_data`  out  DATA_WIDTH  stream word; registered.
- `m_last`  out  1  final word of current burst; registered.
- `m_ready`  in  1  downstream accept.
- `busy`  out  1  high in BURST or DRAIN.
- `cur_len`  out  $clog2(FIFO_DEPTH)+1  length latched for the current burst.
- `burst_cnt`  out  16  completed bursts, wraps at 2^16.

## Operation
- FSM states: IDLE, BURST, DRAIN.
- IDLE -> BURST when `fifo_rd_data_count >= BURST_LEN`. Latch `cur_len = BURST_LEN`.
- IDLE -> BURST when TIMEOUT != 0, count is in 1..BURST_LEN-1, and the idle timer equals TIMEOUT. Latch `cur_len = count`.
- Idle timer: increments in IDLE while count is nonzero and below BURST_LEN. It clears on any other condition and on leaving IDLE. It saturates at TIMEOUT. Width is `$clog2(TIMEOUT+1)`, minimum 1.
- BURST: `remaining` loads `cur_len` on entry.
  - `fifo_rd_en = BURST && remaining!=0 && fifo_valid && (!m_valid || m_ready)`.
  - Each pop loads `m_data <= fifo_dout` and sets `m_valid <= 1`.
  - Each pop sets `m_last <= (remaining==1)` and decrements `remaining`.
- BURST -> DRAIN on the pop with `remaining==1`.
- DRAIN -> IDLE when `m_valid && m_ready && m_last`. On that cycle `burst_cnt` increments and `cur_len` holds until the next burst starts.
- When m_valid && m_ready and no pop occurs, clear `m_valid` and `m_last`.
- Stall rule: while `m_valid && !m_ready`, the values of `m_data`/`m_last` are held and `fifo_rd_en` stays 0.
- `fifo_valid` low mid-burst: stall, no error. The burst resumes when the head is valid.

## Timing
- Reset values: all outputs 0; FSM in IDLE; timer 0; remaining 0.
- Reset mid-burst: the next cycle shows `m_valid=0`. Words already popped are discarded, and `burst_cnt` is not incremented.
- Latency: a threshold met at edge N gives BURST from N+1. The first `fifo_rd_en` is in cycle N+1 and the first `m_valid` is at N+2.
- Throughput: 1 word/cycle with `m_ready` held high; a burst of L words occupies L consecutive `m_valid` cycles.
- Bubble: exactly 2 idle cycles between back-to-back bursts, because DRAIN->IDLE->BURST re-evaluates the count after the FIFO count has settled.
- BURST_LEN=1: every word has `m_last=1`.
- Partial flush fires on the cycle after the timer reaches TIMEOUT.
- If the count reaches BURST_LEN on the same cycle as the timeout, the full-burst rule wins.

## Structure
- Shared package `fifo_pkg`: FSM state enum (IDLE/BURST/DRAIN) and a count-width helper constant function.
- One natural sub-module, `stream_out_reg`, holding the registered `m_valid`/`m_data`/`m_last` stage with the stall logic. The FSM, timer, and counters live in the top.

## Test plan
- Load 8 words 0x0123..0x0A2A into the FIFO, with BURST_LEN=8 and `m_ready`=1. Expect 8 contiguous `m_valid` cycles with data in order, `m_last` only on 0x0A2A, `burst_cnt`=1, and `cur_len`=8.
- Load 16 words, keep `m_ready`=1. Expect two bursts separated by exactly 2 idle cycles, `burst_cnt`=2, and the FIFO empty at the end.
- Load 3 words with TIMEOUT=64. Expect no output for 64 idle cycles, then a 3-word burst with `m_last` on word 3 and `cur_len`=3. With TIMEOUT=0, expect no output at all.
- Toggle `m_ready` 1/0 every cycle during a burst. Expect `m_data` to hold through each stall, no `fifo_rd_en` while stalled, no lost or duplicated words, and 8 words delivered.
- Assert `reset`=0 for 1 cycle after word 4 of a burst. Expect `m_valid`=0 and `busy`=0 on the next cycle, `burst_cnt`=0, and a new burst starting once 8 words are again present.

Source files
------------

// File: rtl/fifo_burst_reader_pkg.sv
// Shared types and width helpers for the FIFO burst reader.
package fifo_pkg;

    // Reader controller states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Width of a word count able to hold 0..depth.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Width of the idle timer; never narrower than one bit.
    function automatic int timer_width(input int timeout);
        return (timeout < 2) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/fifo_burst_reader_if.sv
// FWFT FIFO read port plus valid/ready output stream of the burst reader.
interface fifo_burst_reader_if
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 16
);
    localparam int CW = count_width(FIFO_DEPTH);

    logic                  fifo_valid;
    logic [DATA_WIDTH-1:0] fifo_dout;
    logic [CW-1:0]         fifo_rd_data_count;
    logic                  fifo_rd_en;
    logic                  m_valid;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_last;
    logic                  m_ready;

    // The reader: consumes the FIFO head and drives the stream.
    modport master (
        input  fifo_valid, fifo_dout, fifo_rd_data_count, m_ready,
        output fifo_rd_en, m_valid, m_data, m_last
    );

    // The surroundings: FIFO read side and downstream consumer.
    modport slave (
        output fifo_valid, fifo_dout, fifo_rd_data_count, m_ready,
        input  fifo_rd_en, m_valid, m_data, m_last
    );
endinterface

// File: rtl/fifo_burst_reader_stream_out_reg.sv
// Registered valid/data/last output stage with stall handling.
module stream_out_reg #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  last_in,
    input  logic                  ready,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  last,
    output logic                  can_accept
);
    // A new word may be loaded when the stage is empty or being drained this cycle.
    assign can_accept = !valid || ready;

    // Load on pop, empty on accept without pop, otherwise hold (stall).
    always_ff @(posedge clock) begin
        if (!reset) begin
            valid <= 1'b0;
            data  <= '0;
            last  <= 1'b0;
        end else if (pop) begin
            valid <= 1'b1;
            data  <= din;
            last  <= last_in;
        end else if (valid && ready) begin
            valid <= 1'b0;
            last  <= 1'b0;
        end
    end
endmodule

// File: rtl/fifo_burst_reader.sv
// Drains an FWFT FIFO in fixed-length bursts, flushing partial bursts after an idle timeout.
module fifo_burst_reader
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 16,
    parameter int BURST_LEN  = 8,
    parameter int TIMEOUT    = 64
) (
    input  logic                               clock,
    input  logic                               reset,
    fifo_burst_reader_if.master                bus,
    output logic                               busy,
    output logic [count_width(FIFO_DEPTH)-1:0] cur_len,
    output logic [15:0]                        burst_cnt
);
    localparam int CW = count_width(FIFO_DEPTH);
    localparam int TW = timer_width(TIMEOUT);
    localparam logic [CW-1:0] BURST_LEN_C = CW'(BURST_LEN);
    localparam logic [TW-1:0] TIMEOUT_C   = TW'(TIMEOUT);

    state_t        state_reg, state_next;
    logic [CW-1:0] remaining_reg;
    logic [CW-1:0] cur_len_reg;
    logic [TW-1:0] timer_reg;
    logic [15:0]   burst_cnt_reg;

    logic [CW-1:0] count;
    logic [CW-1:0] load_len;
    logic          partial_pending;
    logic          start;
    logic          pop;
    logic          burst_done;
    logic          can_accept;

    assign count = bus.fifo_rd_data_count;

    // Next-state decode: burst start, per-word pop, and burst completion.
    always_comb begin
        state_next      = state_reg;
        load_len        = BURST_LEN_C;
        start           = 1'b0;
        pop             = 1'b0;
        burst_done      = 1'b0;
        partial_pending = (count != '0) && (count < BURST_LEN_C);
        case (state_reg)
            IDLE: begin
                // A full burst takes priority over a timeout on the same cycle.
                if (count >= BURST_LEN_C) begin
                    state_next = BURST;
                    start      = 1'b1;
                end else if ((TIMEOUT != 0) && partial_pending && (timer_reg == TIMEOUT_C)) begin
                    state_next = BURST;
                    start      = 1'b1;
                    load_len   = count;
                end
            end
            BURST: begin
                pop = (remaining_reg != '0) && bus.fifo_valid && can_accept;
                if (pop && (remaining_reg == CW'(1))) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (bus.m_valid && bus.m_ready && bus.m_last) begin
                    state_next = IDLE;
                    burst_done = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State, burst length/remaining and completed-burst counter.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg     <= IDLE;
            remaining_reg <= '0;
            cur_len_reg   <= '0;
            burst_cnt_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (start) begin
                remaining_reg <= load_len;
                cur_len_reg   <= load_len;
            end else if (pop) begin
                remaining_reg <= remaining_reg - CW'(1);
            end
            if (burst_done) begin
                burst_cnt_reg <= burst_cnt_reg + 16'd1;
            end
        end
    end

    // Idle timer: runs while a partial burst waits in IDLE, saturating at TIMEOUT.
    always_ff @(posedge clock) begin
        if (!reset) begin
            timer_reg <= '0;
        end else if ((state_reg == IDLE) && (state_next == IDLE) && partial_pending) begin
            if (timer_reg != TIMEOUT_C) begin
                timer_reg <= timer_reg + TW'(1);
            end
        end else begin
            timer_reg <= '0;
        end
    end

    stream_out_reg #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_out (
        .clock      (clock),
        .reset      (reset),
        .pop        (pop),
        .din        (bus.fifo_dout),
        .last_in    (remaining_reg == CW'(1)),
        .ready      (bus.m_ready),
        .valid      (bus.m_valid),
        .data       (bus.m_data),
        .last       (bus.m_last),
        .can_accept (can_accept)
    );

    assign bus.fifo_rd_en = pop;
    assign busy           = (state_reg != IDLE);
    assign cur_len        = cur_len_reg;
    assign burst_cnt      = burst_cnt_reg;
endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: behavioural FWFT FIFO, stream monitor and per-scenario checks.
module tb_fifo_burst_reader;
    import fifo_pkg::*;

    localparam int DW = 16, FD = 16, BL = 8, TO = 64, CW = 5, MEMSZ = 1024;

    logic clock = 1'b0;
    always #5 clock = ~clock;
    logic reset;
    int   cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;
    int exp_bursts = 0;

    fifo_burst_reader_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(FD)) if_a(), if_b();
    logic          busy_a, busy_b;
    logic [CW-1:0] cur_len_a, cur_len_b;
    logic [15:0]   bcnt_a, bcnt_b;
    logic          ready_a;

    fifo_burst_reader #(.DATA_WIDTH(DW), .FIFO_DEPTH(FD), .BURST_LEN(BL), .TIMEOUT(TO)) dut_a (
        .clock(clock), .reset(reset), .bus(if_a.master),
        .busy(busy_a), .cur_len(cur_len_a), .burst_cnt(bcnt_a));
    fifo_burst_reader #(.DATA_WIDTH(DW), .FIFO_DEPTH(FD), .BURST_LEN(BL), .TIMEOUT(0)) dut_b (
        .clock(clock), .reset(reset), .bus(if_b.master),
        .busy(busy_b), .cur_len(cur_len_b), .burst_cnt(bcnt_b));

    // Behavioural FWFT FIFOs, one per DUT.
    logic [DW-1:0] fmem [2][MEMSZ];
    int            rd_ptr [2];
    int            wr_ptr [2];
    logic          push_en [2];
    logic [DW-1:0] push_data [2];
    logic          rd_en [2];
    assign rd_en[0] = if_a.fifo_rd_en;
    assign rd_en[1] = if_b.fifo_rd_en;
    always @(posedge clock) begin
        for (int i = 0; i < 2; i++) begin
            if (rd_en[i] && (rd_ptr[i] != wr_ptr[i])) rd_ptr[i] <= rd_ptr[i] + 1;
            if (push_en[i]) begin
                fmem[i][wr_ptr[i] % MEMSZ] <= push_data[i];
                wr_ptr[i] <= wr_ptr[i] + 1;
            end
        end
    end
    assign if_a.fifo_valid         = (rd_ptr[0] != wr_ptr[0]);
    assign if_a.fifo_dout          = fmem[0][rd_ptr[0] % MEMSZ];
    assign if_a.fifo_rd_data_count = CW'(wr_ptr[0] - rd_ptr[0]);
    assign if_a.m_ready            = ready_a;
    assign if_b.fifo_valid         = (rd_ptr[1] != wr_ptr[1]);
    assign if_b.fifo_dout          = fmem[1][rd_ptr[1] % MEMSZ];
    assign if_b.fifo_rd_data_count = CW'(wr_ptr[1] - rd_ptr[1]);
    assign if_b.m_ready            = 1'b1;

    // Stream monitor: every accepted word with its cycle number.
    typedef struct { logic [DW-1:0] d; logic l; int c; } obs_t;
    obs_t obs_a[$];
    obs_t obs_b[$];
    always @(negedge clock) begin
        if (if_a.m_valid && if_a.m_ready) obs_a.push_back('{d: if_a.m_data, l: if_a.m_last, c: cyc});
        if (if_b.m_valid && if_b.m_ready) obs_b.push_back('{d: if_b.m_data, l: if_b.m_last, c: cyc});
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic push_word(input int i, input logic [DW-1:0] d, output int pc);
        int guard = 0;
        while (((wr_ptr[i] - rd_ptr[i]) >= FD) && (guard < 1000)) begin
            step();
            guard++;
        end
        if (guard >= 1000) begin
            checks++; errors++;
            $display("FAIL push_timeout: fifo %0d still full after %0d cycles", i, guard);
        end
        push_en[i]   = 1'b1;
        push_data[i] = d;
        pc           = cyc + 1;
        step();
        push_en[i]   = 1'b0;
    endtask

    task automatic wait_words(input int i, input int n, input int budget);
        int k = 0;
        while ((((i == 0) ? obs_a.size() : obs_b.size()) < n) && (k < budget)) begin
            step();
            k++;
        end
        if (k >= budget) begin
            checks++; errors++;
            $display("FAIL wait_words: dut %0d got %0d words, required %0d within %0d cycles",
                     i, (i == 0) ? obs_a.size() : obs_b.size(), n, budget);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; ready_a = 1'b1;
        push_en[0] = 1'b0; push_en[1] = 1'b0;
        push_data[0] = '0; push_data[1] = '0;
        repeat (3) step();
        checks++; if (if_a.m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %b required 0", if_a.m_valid); end
        checks++; if (if_a.m_last !== 1'b0) begin errors++; $display("FAIL reset_m_last: got %b required 0", if_a.m_last); end
        checks++; if (if_a.m_data !== '0) begin errors++; $display("FAIL reset_m_data: got %h required 0", if_a.m_data); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy_a); end
        checks++; if (cur_len_a !== '0) begin errors++; $display("FAIL reset_cur_len: got %0d required 0", cur_len_a); end
        checks++; if (bcnt_a !== 16'd0) begin errors++; $display("FAIL reset_burst_cnt: got %0d required 0", bcnt_a); end
        checks++; if (if_a.fifo_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b required 0", if_a.fifo_rd_en); end
        reset = 1'b1;
        step();
    endtask

    task automatic test_single_burst();
        logic [DW-1:0] w [8];
        int pc, last_pc;
        w = '{16'h0123, 16'h0456, 16'h0789, 16'h0ABC, 16'h0DEF, 16'h0321, 16'h0654, 16'h0A2A};
        obs_a.delete();
        for (int k = 0; k < 8; k++) begin
            push_word(0, w[k], pc);
            last_pc = pc;
        end
        wait_words(0, 8, 100);
        repeat (3) step();
        exp_bursts++;
        checks++; if (obs_a.size() != 8) begin errors++; $display("FAIL single_count: got %0d words required 8", obs_a.size()); end
        for (int k = 0; k < obs_a.size() && k < 8; k++) begin
            checks++; if (obs_a[k].d !== w[k] || obs_a[k].l !== (k == 7)) begin
                errors++; $display("FAIL single_word%0d: got %h/last=%b required %h/last=%b", k, obs_a[k].d, obs_a[k].l, w[k], k == 7);
            end
            if (k > 0) begin
                checks++; if (obs_a[k].c != obs_a[k-1].c + 1) begin
                    errors++; $display("FAIL single_contig%0d: got cycle %0d required %0d", k, obs_a[k].c, obs_a[k-1].c + 1);
                end
            end
        end
        if (obs_a.size() > 0) begin
            checks++; if (obs_a[0].c != last_pc + 2) begin
                errors++; $display("FAIL single_latency: first valid cycle %0d required %0d", obs_a[0].c, last_pc + 2);
            end
        end
        checks++; if (bcnt_a !== 16'(exp_bursts)) begin errors++; $display("FAIL single_burst_cnt: got %0d required %0d", bcnt_a, exp_bursts); end
        checks++; if (cur_len_a !== CW'(8)) begin errors++; $display("FAIL single_cur_len: got %0d required 8", cur_len_a); end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] exp_q[$];
        int pc;
        obs_a.delete();
        for (int k = 0; k < 16; k++) exp_q.push_back(DW'($urandom));
        for (int k = 0; k < 16; k++) push_word(0, exp_q[k], pc);
        wait_words(0, 16, 200);
        repeat (3) step();
        exp_bursts += 2;
        checks++; if (obs_a.size() != 16) begin errors++; $display("FAIL b2b_count: got %0d words required 16", obs_a.size()); end
        for (int k = 0; k < obs_a.size() && k < 16; k++) begin
            checks++; if (obs_a[k].d !== exp_q[k] || obs_a[k].l !== ((k + 1) % BL == 0)) begin
                errors++; $display("FAIL b2b_word%0d: got %h/last=%b required %h/last=%b", k, obs_a[k].d, obs_a[k].l, exp_q[k], (k + 1) % BL == 0);
            end
            if (k > 0 && (k % BL) != 0) begin
                checks++; if (obs_a[k].c != obs_a[k-1].c + 1) begin
                    errors++; $display("FAIL b2b_contig%0d: got cycle %0d required %0d", k, obs_a[k].c, obs_a[k-1].c + 1);
                end
            end
        end
        if (obs_a.size() >= 9) begin
            checks++; if (obs_a[8].c - obs_a[7].c != 3) begin
                errors++; $display("FAIL b2b_gap: got %0d idle cycles required 2", obs_a[8].c - obs_a[7].c - 1);
            end
        end
        checks++; if (wr_ptr[0] != rd_ptr[0]) begin errors++; $display("FAIL b2b_fifo_empty: got %0d words left required 0", wr_ptr[0] - rd_ptr[0]); end
        checks++; if (bcnt_a !== 16'(exp_bursts)) begin errors++; $display("FAIL b2b_burst_cnt: got %0d required %0d", bcnt_a, exp_bursts); end
    endtask

    task automatic test_timeout();
        logic [DW-1:0] exp_q[$];
        int pc, first_pc;
        obs_a.delete(); obs_b.delete();
        for (int k = 0; k < 3; k++) exp_q.push_back(DW'($urandom));
        for (int k = 0; k < 3; k++) begin
            push_word(0, exp_q[k], pc);
            if (k == 0) first_pc = pc;
        end
        for (int k = 0; k < 3; k++) push_word(1, DW'($urandom), pc);
        wait_words(0, 3, TO + 50);
        repeat (3) step();
        exp_bursts++;
        checks++; if (obs_a.size() != 3) begin errors++; $display("FAIL tmo_count: got %0d words required 3", obs_a.size()); end
        for (int k = 0; k < obs_a.size() && k < 3; k++) begin
            checks++; if (obs_a[k].d !== exp_q[k] || obs_a[k].l !== (k == 2)) begin
                errors++; $display("FAIL tmo_word%0d: got %h/last=%b required %h/last=%b", k, obs_a[k].d, obs_a[k].l, exp_q[k], k == 2);
            end
        end
        if (obs_a.size() > 0) begin
            checks++; if (obs_a[0].c != first_pc + TO + 2) begin
                errors++; $display("FAIL tmo_latency: first valid cycle %0d required %0d", obs_a[0].c, first_pc + TO + 2);
            end
        end
        checks++; if (cur_len_a !== CW'(3)) begin errors++; $display("FAIL tmo_cur_len: got %0d required 3", cur_len_a); end
        checks++; if (bcnt_a !== 16'(exp_bursts)) begin errors++; $display("FAIL tmo_burst_cnt: got %0d required %0d", bcnt_a, exp_bursts); end
        repeat (TO + 40) step();
        checks++; if (obs_b.size() != 0) begin errors++; $display("FAIL tmo0_no_output: got %0d words required 0", obs_b.size()); end
        checks++; if (busy_b !== 1'b0 || bcnt_b !== 16'd0) begin
            errors++; $display("FAIL tmo0_idle: got busy=%b burst_cnt=%0d required busy=0 burst_cnt=0", busy_b, bcnt_b);
        end
    endtask

    task automatic test_stall();
        logic [DW-1:0] exp_q[$];
        logic [DW-1:0] hold_d;
        logic hold_l, stalled;
        int pc, stalls;
        obs_a.delete(); ready_a = 1'b1;
        for (int k = 0; k < 8; k++) exp_q.push_back(DW'($urandom));
        for (int k = 0; k < 8; k++) push_word(0, exp_q[k], pc);
        stalled = 1'b0; stalls = 0; hold_d = '0; hold_l = 1'b0;
        for (int k = 0; k < 200 && obs_a.size() < 8; k++) begin
            step();
            if (stalled) begin
                checks++; if (if_a.m_valid !== 1'b1 || if_a.m_data !== hold_d || if_a.m_last !== hold_l) begin
                    errors++; $display("FAIL stall_hold: got v=%b d=%h l=%b required v=1 d=%h l=%b", if_a.m_valid, if_a.m_data, if_a.m_last, hold_d, hold_l);
                end
            end
            ready_a = k[0];
            #1;
            stalled = if_a.m_valid && !ready_a;
            if (stalled) begin
                stalls++; hold_d = if_a.m_data; hold_l = if_a.m_last;
                checks++; if (if_a.fifo_rd_en !== 1'b0) begin errors++; $display("FAIL stall_rd_en: got %b required 0", if_a.fifo_rd_en); end
            end
        end
        ready_a = 1'b1;
        wait_words(0, 8, 50);
        repeat (3) step();
        exp_bursts++;
        checks++; if (stalls == 0) begin errors++; $display("FAIL stall_seen: got 0 stall cycles required at least 1"); end
        checks++; if (obs_a.size() != 8) begin errors++; $display("FAIL stall_count: got %0d words required 8", obs_a.size()); end
        for (int k = 0; k < obs_a.size() && k < 8; k++) begin
            checks++; if (obs_a[k].d !== exp_q[k] || obs_a[k].l !== (k == 7)) begin
                errors++; $display("FAIL stall_word%0d: got %h/last=%b required %h/last=%b", k, obs_a[k].d, obs_a[k].l, exp_q[k], k == 7);
            end
        end
        checks++; if (bcnt_a !== 16'(exp_bursts)) begin errors++; $display("FAIL stall_burst_cnt: got %0d required %0d", bcnt_a, exp_bursts); end
    endtask

    task automatic test_random();
        logic [DW-1:0] exp_q[$];
        logic [DW-1:0] hold_d;
        logic hold_l, stalled;
        int pc;
        obs_a.delete();
        for (int k = 0; k < 24; k++) exp_q.push_back(DW'($urandom));
        stalled = 1'b0; hold_d = '0; hold_l = 1'b0;
        fork
            begin
                for (int k = 0; k < 24; k++) push_word(0, exp_q[k], pc);
            end
            begin
                for (int k = 0; k < 3000 && obs_a.size() < 24; k++) begin
                    step();
                    if (stalled) begin
                        checks++; if (if_a.m_valid !== 1'b1 || if_a.m_data !== hold_d || if_a.m_last !== hold_l) begin
                            errors++; $display("FAIL rand_hold: got v=%b d=%h l=%b required v=1 d=%h l=%b", if_a.m_valid, if_a.m_data, if_a.m_last, hold_d, hold_l);
                        end
                    end
                    ready_a = 1'($urandom_range(0, 1));
                    #1;
                    stalled = if_a.m_valid && !ready_a;
                    if (stalled) begin
                        hold_d = if_a.m_data; hold_l = if_a.m_last;
                        checks++; if (if_a.fifo_rd_en !== 1'b0) begin errors++; $display("FAIL rand_rd_en: got %b required 0", if_a.fifo_rd_en); end
                    end
                end
            end
        join
        ready_a = 1'b1;
        wait_words(0, 24, 100);
        repeat (3) step();
        exp_bursts += 3;
        checks++; if (obs_a.size() != 24) begin errors++; $display("FAIL rand_count: got %0d words required 24", obs_a.size()); end
        for (int k = 0; k < obs_a.size() && k < 24; k++) begin
            checks++; if (obs_a[k].d !== exp_q[k] || obs_a[k].l !== ((k + 1) % BL == 0)) begin
                errors++; $display("FAIL rand_word%0d: got %h/last=%b required %h/last=%b", k, obs_a[k].d, obs_a[k].l, exp_q[k], (k + 1) % BL == 0);
            end
        end
        checks++; if (bcnt_a !== 16'(exp_bursts)) begin errors++; $display("FAIL rand_burst_cnt: got %0d required %0d", bcnt_a, exp_bursts); end
    endtask

    task automatic test_reset_mid_burst();
        logic [DW-1:0] exp_q[$];
        int pc, rd_snap;
        obs_a.delete(); ready_a = 1'b1;
        for (int k = 0; k < 8; k++) push_word(0, DW'($urandom), pc);
        wait_words(0, 4, 100);
        reset = 1'b0;
        step();
        reset = 1'b1;
        exp_bursts = 0;
        checks++; if (if_a.m_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_m_valid: got %b required 0", if_a.m_valid); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b required 0", busy_a); end
        checks++; if (bcnt_a !== 16'd0) begin errors++; $display("FAIL rst_mid_burst_cnt: got %0d required 0", bcnt_a); end
        rd_snap = rd_ptr[0];
        obs_a.delete();
        for (int k = 0; k < 8; k++) push_word(0, DW'($urandom), pc);
        for (int k = 0; k < 8; k++) exp_q.push_back(fmem[0][(rd_snap + k) % MEMSZ]);
        wait_words(0, 8, 200);
        repeat (3) step();
        exp_bursts++;
        checks++; if (obs_a.size() < 8) begin errors++; $display("FAIL rst_mid_count: got %0d words required 8", obs_a.size()); end
        for (int k = 0; k < obs_a.size() && k < 8; k++) begin
            checks++; if (obs_a[k].d !== exp_q[k] || obs_a[k].l !== (k == 7)) begin
                errors++; $display("FAIL rst_mid_word%0d: got %h/last=%b required %h/last=%b", k, obs_a[k].d, obs_a[k].l, exp_q[k], k == 7);
            end
        end
        checks++; if (bcnt_a !== 16'(exp_bursts)) begin errors++; $display("FAIL rst_mid_new_burst: got burst_cnt %0d required %0d", bcnt_a, exp_bursts); end
        checks++; if (cur_len_a !== CW'(8)) begin errors++; $display("FAIL rst_mid_cur_len: got %0d required 8", cur_len_a); end
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_back_to_back();
        test_timeout();
        test_stall();
        test_random();
        test_reset_mid_burst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
